muldiv_unit: RTL

Iterative integer multiply/divide unit for the EX stage of the pipelined RISC-V core, implementing the full M-extension set plus the RV64 "W" word variants. It is parametrised in datapath width and adds multi-cycle execution with a start/busy/done handshake, a pipeline-freeze input and a flush input. The hazard logic holds the upstream stages while `busy` is high. Kept results feed the EX/MEM register.

---
 rtl/muldiv_unit.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit with RV64 word variants.
// One bit per cycle: shift-add multiply, restoring divide, fixed latency.
module muldiv_unit #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              en,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic              word,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic              kill,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  localparam int unsigned H  = DATA_W / 2;
  localparam int unsigned CW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [2:0]            op_q, op_d;
  logic                  word_q, word_d;
  logic [DATA_W-1:0]     a_q, a_d;
  logic [DATA_W-1:0]     b_q, b_d;
  logic [DATA_W-1:0]     a_ext_q, a_ext_d;
  logic [DATA_W-1:0]     a_mag_q, a_mag_d;
  logic [DATA_W-1:0]     b_mag_q, b_mag_d;
  logic                  neg_q, neg_d;
  logic                  neg_rem_q, neg_rem_d;
  logic                  dz_q, dz_d;
  logic                  ovf_q, ovf_d;
  logic [2*DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]     quot_q, quot_d;
  logic [DATA_W-1:0]     rem_q, rem_d;
  logic [DATA_W-1:0]     result_q, result_d;

  logic                  is_div, sgn_a, sgn_b, neg_a, neg_b;
  logic [DATA_W-1:0]     a_ext, b_ext, a_mag, b_mag, min_val;
  logic                  dz_flag, ovf_flag;
  logic [2*DATA_W-1:0]   acc_step;
  logic [DATA_W:0]       rem_sh;
  logic                  rem_ge;
  logic [DATA_W-1:0]     rem_sub;
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quot_fix, rem_fix, sel, res_fix;

  // Datapath helpers for PREP, CALC and FIX; only the current state's values are used.
  always_comb begin
    is_div = op_q[2];
    sgn_a  = is_div ? ~op_q[0] : (op_q == 3'b001 || op_q == 3'b010);
    sgn_b  = is_div ? ~op_q[0] : (op_q == 3'b001);

    a_ext = a_q;
    b_ext = b_q;
    if (word_q) begin
      a_ext = {{H{sgn_a & a_q[H-1]}}, a_q[H-1:0]};
      b_ext = {{H{sgn_b & b_q[H-1]}}, b_q[H-1:0]};
    end
    neg_a = sgn_a & a_ext[DATA_W-1];
    neg_b = sgn_b & b_ext[DATA_W-1];
    a_mag = neg_a ? -a_ext : a_ext;
    b_mag = neg_b ? -b_ext : b_ext;

    min_val  = word_q ? {{(H+1){1'b1}}, {(H-1){1'b0}}} : {1'b1, {(DATA_W-1){1'b0}}};
    dz_flag  = is_div && (b_ext == '0);
    ovf_flag = is_div && !op_q[0] && (a_ext == min_val) && (b_ext == '1);

    // MSB-first: multiplier bit and dividend bit both indexed by the down-counter
    acc_step = {acc_q[2*DATA_W-2:0], 1'b0} + (b_mag_q[cnt_q] ? {{DATA_W{1'b0}}, a_mag_q} : '0);
    rem_sh   = {rem_q, a_mag_q[cnt_q]};
    rem_ge   = rem_sh >= {1'b0, b_mag_q};
    rem_sub  = rem_sh[DATA_W-1:0] - b_mag_q;

    prod_fix = neg_q ? -acc_q : acc_q;
    quot_fix = neg_q ? -quot_q : quot_q;
    rem_fix  = neg_rem_q ? -rem_q : rem_q;
    if (dz_q) begin
      quot_fix = '1;
      rem_fix  = a_ext_q;
    end else if (ovf_q) begin
      quot_fix = a_ext_q;
      rem_fix  = '0;
    end

    if (!op_q[2]) begin
      sel = (word_q || op_q[1:0] == 2'b00) ? prod_fix[DATA_W-1:0] : prod_fix[2*DATA_W-1:DATA_W];
    end else begin
      sel = op_q[1] ? rem_fix : quot_fix;
    end
    res_fix = word_q ? {{H{sel[H-1]}}, sel[H-1:0]} : sel;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    word_d    = word_q;
    a_d       = a_q;
    b_d       = b_q;
    a_ext_d   = a_ext_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    acc_d     = acc_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    result_d  = result_q;

    if (kill) begin
      state_d = S_IDLE;
    end else if (en) begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            op_d    = op;
            word_d  = word;
            a_d     = operand_a;
            b_d     = operand_b;
            state_d = S_PREP;
          end
        end
        S_PREP: begin
          a_ext_d   = a_ext;
          a_mag_d   = a_mag;
          b_mag_d   = b_mag;
          neg_d     = neg_a ^ neg_b;
          neg_rem_d = neg_a;
          dz_d      = dz_flag;
          ovf_d     = ovf_flag;
          acc_d     = '0;
          quot_d    = '0;
          rem_d     = '0;
          cnt_d     = word_q ? CW'(H - 1) : CW'(DATA_W - 1);
          state_d   = S_CALC;
        end
        S_CALC: begin
          acc_d  = acc_step;
          rem_d  = rem_ge ? rem_sub : rem_sh[DATA_W-1:0];
          quot_d = {quot_q[DATA_W-2:0], rem_ge};
          if (cnt_q == '0) begin
            state_d = S_FIX;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_FIX: begin
          result_d = res_fix;
          state_d  = S_DONE;
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      word_q    <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      a_ext_q   <= '0;
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      acc_q     <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      word_q    <= word_d;
      a_q       <= a_d;
      b_q       <= b_d;
      a_ext_q   <= a_ext_d;
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      acc_q     <= acc_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
